// File: rtl/pa_capture_dma.sv
// Parallel-input capture into a small first-word-fall-through FIFO, with a
// level-based DMA request and sticky overflow/underflow flags.
module pa_capture_dma #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int DIV_W     = 8,
   parameter int DMA_LEVEL = 1
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     enable,
   input  logic [1:0]               mode,
   input  logic [DIV_W-1:0]         div,
   input  logic [WIDTH-1:0]         pi,
   input  logic                     strobe,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     dma,
   output logic                     overflow,
   output logic                     underflow,
   input  logic                     flag_clr,
   output logic                     dbg_state
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam int L  = $clog2(WIDTH);
   localparam int KW = 3;

   localparam logic [1:0] MODE_PAT    = 2'b00;
   localparam logic [1:0] MODE_PERIOD = 2'b01;
   localparam logic [1:0] MODE_STROBE = 2'b10;
   localparam logic [1:0] MODE_OFF    = 2'b11;

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [DIV_W-1:0]   cnt_q, cnt_d;
   logic               strobe_q;
   logic [KW-1:0]      k_q, k_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [LW-1:0]      level_q, level_d;
   logic               ovf_q, ovf_d;
   logic               udf_q, udf_d;
   logic [WIDTH-1:0]   mem_q [DEPTH];

   logic               tick;
   logic               push_req;
   logic [WIDTH-1:0]   push_data;
   logic               empty, full;
   logic               pop, wr;

   // P[0] is all ones; P[k] sets bit i to bit (L-k) of the index i.
   function automatic logic [WIDTH-1:0] pattern(input logic [KW-1:0] k);
      logic [WIDTH-1:0] p;
      logic [31:0]      idx;
      int               sel;
      p = '1;
      if (k != '0) begin
         sel = L - int'(k);
         for (int i = 0; i < WIDTH; i++) begin
            idx  = i;
            p[i] = idx[sel];
         end
      end
      return p;
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tick    = 1'b0;
      case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (enable && mode != MODE_OFF) state_d = S_RUN;
         end
         S_RUN: begin
            if (cnt_q == div) begin
               tick  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + DIV_W'(1);
            end
            // Leaving RUN clears the counter so re-entry always starts a full period.
            if (!enable || mode == MODE_OFF) begin
               state_d = S_IDLE;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   always_comb begin
      push_req = 1'b0;
      if (state_q == S_RUN) begin
         case (mode)
            MODE_PAT, MODE_PERIOD: push_req = tick;
            MODE_STROBE:           push_req = strobe & ~strobe_q;
            default:               push_req = 1'b0;
         endcase
      end
   end

   assign push_data = (mode == MODE_PAT) ? pattern(k_q) : pi;

   assign empty = (level_q == '0);
   assign full  = (level_q == LW'(DEPTH));
   assign pop   = rd_en & ~empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign wr    = push_req & (~full | pop);

   always_comb begin
      k_d      = k_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      level_d  = level_q;
      if (push_req && mode == MODE_PAT) begin
         k_d = (k_q == KW'(L)) ? '0 : k_q + KW'(1);
      end
      if (wr)  wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({wr, pop})
         2'b10:   level_d = level_q + LW'(1);
         2'b01:   level_d = level_q - LW'(1);
         default: level_d = level_q;
      endcase
      ovf_d = (ovf_q & ~flag_clr) | (push_req & full & ~rd_en);
      udf_d = (udf_q & ~flag_clr) | (rd_en & empty);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         strobe_q <= 1'b0;
         k_q      <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         level_q  <= '0;
         ovf_q    <= 1'b0;
         udf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         strobe_q <= strobe;
         k_q      <= k_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         level_q  <= level_d;
         ovf_q    <= ovf_d;
         udf_q    <= udf_d;
      end
   end

   // Storage needs no reset: the pointers and level define what is valid.
   always_ff @(posedge clock) begin
      if (wr && !reset) mem_q[wr_ptr_q] <= push_data;
   end

   assign rd_data   = empty ? '0 : mem_q[rd_ptr_q];
   assign level     = level_q;
   assign dma       = (level_q >= LW'(DMA_LEVEL));
   assign overflow  = ovf_q;
   assign underflow = udf_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_pa_capture_dma.sv
// Directed bench for pa_capture_dma: pattern, periodic, strobe capture, FIFO
// corner cases, sticky flags, DMA threshold and mid-stream reset.
module tb_pa_capture_dma;

   logic       clock = 1'b0;
   logic       reset;
   logic       enable;
   logic [1:0] mode;
   logic [7:0] div;
   logic [7:0] pi;
   logic       strobe;
   logic       rd_en;
   logic       flag_clr;

   logic [7:0] rd_data, rd_data3;
   logic [2:0] level, level3;
   logic       dma, dma3;
   logic       overflow, overflow3;
   logic       underflow, underflow3;
   logic       dbg_state, dbg_state3;

   int n_checks = 0;
   int n_pass   = 0;

   logic [7:0] exp_q[$];
   logic [7:0] exp_v;

   pa_capture_dma #(.WIDTH(8), .DEPTH(4), .DIV_W(8), .DMA_LEVEL(1)) dut (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .div(div),
      .pi(pi), .strobe(strobe), .rd_en(rd_en), .rd_data(rd_data), .level(level),
      .dma(dma), .overflow(overflow), .underflow(underflow), .flag_clr(flag_clr),
      .dbg_state(dbg_state)
   );

   pa_capture_dma #(.WIDTH(8), .DEPTH(4), .DIV_W(8), .DMA_LEVEL(3)) dut3 (
      .clock(clock), .reset(reset), .enable(enable), .mode(mode), .div(div),
      .pi(pi), .strobe(strobe), .rd_en(rd_en), .rd_data(rd_data3), .level(level3),
      .dma(dma3), .overflow(overflow3), .underflow(underflow3), .flag_clr(flag_clr),
      .dbg_state(dbg_state3)
   );

   always #5 clock = ~clock;

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      else n_pass++;
   endtask

   task automatic drain_expect();
      while (exp_q.size() > 0) begin
         exp_v = exp_q.pop_front();
         check("drain_head", rd_data, exp_v);
         rd_en = 1'b1;
         step();
         rd_en = 1'b0;
      end
      check("drain_empty_data", rd_data, 0);
      check("drain_empty_level", level, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; enable = 1'b0; mode = 2'b00; div = 8'd0; pi = 8'h00;
      strobe = 1'b0; rd_en = 1'b0; flag_clr = 1'b0;
      step(); step();
      reset = 1'b0;
      check("rst_level", level, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_dma", dma, 0);
      check("rst_overflow", overflow, 0);
      check("rst_underflow", underflow, 0);
      check("rst_state", dbg_state, 0);

      // Pattern mode, div=1: pushes on every second edge after entering RUN.
      mode = 2'b00; div = 8'd1; enable = 1'b1;
      step();
      check("t1_state_run", dbg_state, 1);
      check("t1_level0", level, 0);
      for (int i = 0; i < 4; i++) begin
         step();
         check("t1_level_gap", level, i);
         step();
         check("t1_level_push", level, i + 1);
         check("t1_head", rd_data, 8'hFF);
         if (i == 0) check("t1_dma_first", dma, 1);
         if (i == 1) check("t1_dma3_lvl2", dma3, 0);
         if (i == 2) check("t1_dma3_lvl3", dma3, 1);
      end
      step(); step();
      check("t1_overflow", overflow, 1);
      check("t1_level_full", level, 4);
      enable = 1'b0;
      step();
      check("t1_state_idle", dbg_state, 0);
      exp_q.push_back(8'hFF); exp_q.push_back(8'hF0);
      exp_q.push_back(8'hCC); exp_q.push_back(8'hAA);
      drain_expect();
      check("t1_dma_empty", dma, 0);
      check("t1_no_underflow", underflow, 0);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      check("t1_ovf_cleared", overflow, 0);

      // Periodic mode, div=3, pi ramps by one each cycle.
      mode = 2'b01; div = 8'd3; pi = 8'h10; enable = 1'b1;
      for (int n = 1; n <= 13; n++) begin
         step();
         pi = pi + 8'd1;
         check("t2_level", level, int'(n >= 5) + int'(n >= 9) + int'(n >= 13));
      end
      enable = 1'b0;
      exp_q.push_back(8'h14); exp_q.push_back(8'h18); exp_q.push_back(8'h1C);
      drain_expect();

      // Strobe mode: only rising edges capture; div is irrelevant.
      begin
         logic       s_tab [7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
         logic [7:0] p_tab [7] = '{8'h41, 8'h42, 8'h43, 8'h44, 8'h55, 8'h66, 8'h67};
         int         l_tab [7] = '{1, 1, 1, 1, 2, 2, 2};
         mode = 2'b10; div = 8'd5; enable = 1'b1; strobe = 1'b0; pi = 8'h40;
         step();
         for (int i = 0; i < 7; i++) begin
            strobe = s_tab[i]; pi = p_tab[i];
            step();
            check("t3_level", level, l_tab[i]);
         end
      end
      exp_q.push_back(8'h41); exp_q.push_back(8'h55);
      drain_expect();

      // Fill, then push and pop together while full.
      for (int i = 0; i < 4; i++) begin
         pi = 8'hA1 + 8'(i); strobe = 1'b1;
         step();
         strobe = 1'b0;
         step();
      end
      check("t4_full", level, 4);
      pi = 8'hA5; strobe = 1'b1; rd_en = 1'b1;
      step();
      strobe = 1'b0; rd_en = 1'b0;
      check("t4_pp_level", level, 4);
      check("t4_pp_no_ovf", overflow, 0);
      check("t4_pp_head", rd_data, 8'hA2);
      exp_q.push_back(8'hA2); exp_q.push_back(8'hA3);
      exp_q.push_back(8'hA4); exp_q.push_back(8'hA5);
      drain_expect();

      // Underflow and flag clear priority.
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("t5_udf_set", underflow, 1);
      check("t5_udf_level", level, 0);
      flag_clr = 1'b1; rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("t5_set_wins", underflow, 1);
      step();
      flag_clr = 1'b0;
      check("t5_cleared", underflow, 0);
      pi = 8'h77; strobe = 1'b1; rd_en = 1'b1;
      step();
      strobe = 1'b0; rd_en = 1'b0;
      check("t5_empty_pp_level", level, 1);
      check("t5_empty_pp_data", rd_data, 8'h77);
      check("t5_empty_pp_udf", underflow, 1);
      flag_clr = 1'b1;
      step();
      flag_clr = 1'b0;
      check("t5_clr_again", underflow, 0);

      // Pattern resumes from its retained index, then a mid-stream reset.
      enable = 1'b0; rd_en = 1'b1;
      step();
      step();
      rd_en = 1'b0;
      check("t6_udf", underflow, 1);
      check("t6_idle", dbg_state, 0);
      mode = 2'b00; div = 8'd0; enable = 1'b1;
      step();
      for (int i = 1; i <= 5; i++) begin
         step();
         check("t6_level", level, (i > 4) ? 4 : i);
         check("t6_head", rd_data, 8'hF0);
         if (i == 2) check("t6_dma3_lvl2", dma3, 0);
         if (i == 3) check("t6_dma3_lvl3", dma3, 1);
      end
      check("t6_overflow", overflow, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      check("t6_rst_level", level, 0);
      check("t6_rst_data", rd_data, 0);
      check("t6_rst_dma", dma, 0);
      check("t6_rst_dma3", dma3, 0);
      check("t6_rst_ovf", overflow, 0);
      check("t6_rst_udf", underflow, 0);
      check("t6_rst_state", dbg_state, 0);
      step();
      step();
      check("t6_restart_level", level, 1);
      check("t6_restart_head", rd_data, 8'hFF);
      step();
      rd_en = 1'b1;
      step();
      rd_en = 1'b0;
      check("t6_second_pattern", rd_data, 8'hF0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
